calc_display_scan: RTL

Display-side receiver for the calculator core's digit stream. Samples `status`/`data`/`pos` every cycle and assembles the 8 BCD digits into a shadow buffer. On a complete, well-ordered frame it commits the buffer to a display buffer. It drives an 8-digit multiplexed seven-segment display from that buffer and shows a fixed "Erro" pattern when the core holds its error status.

---
 rtl/calc_display_scan_if.sv | 15 +
 rtl/calc_display_scan.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/calc_display_scan_if.sv
`default_nettype none
// ============================================================================
// Module  : calc_display_scan_if
// Brief   : Digit stream from the calculator core (status, BCD digit, index).
// Revision: 1.0 - initial release
// ============================================================================
interface calc_display_scan_if;
  logic [1:0] status;
  logic [3:0] data;
  logic [3:0] pos;

  modport master (output status, output data, output pos);
  modport slave  (input  status, input  data, input  pos);
endinterface
`default_nettype wire

// File: rtl/calc_display_scan.sv
`default_nettype none
// ============================================================================
// Module  : calc_display_scan
// Brief   : Frames the core's BCD digit stream into a display buffer and scans
//           it onto an 8-digit seven-segment display, with an "Erro" override.
//           Optional macro CALC_DISP_LZB_EN enables leading-zero blanking.
// Revision: 1.0 - initial release
// ============================================================================
module calc_display_scan #(
  parameter int REFRESH_DIV = 50000,
  parameter int ERR_HOLD    = 16
) (
  input  wire logic          clock,
  input  wire logic          reset,
  calc_display_scan_if.slave bus,
  output logic [7:0]         an,
  output logic [6:0]         seg,
  output logic               frame_done,
  output logic               frame_err,
  output logic               err_mode
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int CNT_W = $clog2(ERR_HOLD + 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(ERR_HOLD - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(ERR_HOLD);

  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_R     = 7'h2F;
  localparam logic [6:0] SEG_O     = 7'h23;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_COMMIT  = 2'd2
  } frame_state_t;

  frame_state_t     state, state_next;
  logic [2:0]       expected, expected_next;
  logic [7:0][3:0]  shadow, shadow_upd;
  logic [7:0][3:0]  display;
  logic             shadow_we, commit, err_next;
  logic             stream_valid, digit_ok;

  logic [CNT_W-1:0] err_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       idx;
  logic             blank;
  logic [6:0]       seg_next;

  assign stream_valid = ~bus.status[1];
  assign digit_ok     = (bus.data <= 4'd9);

  function automatic logic [6:0] encode(input logic [3:0] digit);
    case (digit)
      4'd0:    encode = 7'h40;
      4'd1:    encode = 7'h79;
      4'd2:    encode = 7'h24;
      4'd3:    encode = 7'h30;
      4'd4:    encode = 7'h19;
      4'd5:    encode = 7'h12;
      4'd6:    encode = 7'h02;
      4'd7:    encode = 7'h78;
      4'd8:    encode = 7'h00;
      4'd9:    encode = 7'h10;
      default: encode = SEG_BLANK;
    endcase
  endfunction

  // Frame FSM: next state, shadow write enable and pulse requests
  always_comb begin
    state_next    = state;
    expected_next = expected;
    shadow_we     = 1'b0;
    commit        = 1'b0;
    err_next      = 1'b0;
    case (state)
      ST_IDLE, ST_COMMIT: begin
        if (stream_valid && bus.pos == 4'd0 && digit_ok) begin
          shadow_we     = 1'b1;
          expected_next = 3'd1;
          state_next    = ST_COLLECT;
        end else begin
          expected_next = 3'd0;
          state_next    = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (!stream_valid) begin
          expected_next = 3'd0;
          state_next    = ST_IDLE;
        end else if (digit_ok && bus.pos == 4'd0) begin
          shadow_we     = 1'b1;
          expected_next = 3'd1;
        end else if (digit_ok && bus.pos == {1'b0, expected}) begin
          shadow_we = 1'b1;
          if (expected == 3'd7) begin
            commit        = 1'b1;
            expected_next = 3'd0;
            state_next    = ST_COMMIT;
          end else begin
            expected_next = expected + 3'd1;
          end
        end else begin
          err_next      = 1'b1;
          expected_next = 3'd0;
          state_next    = ST_IDLE;
        end
      end
      default: begin
        expected_next = 3'd0;
        state_next    = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    shadow_upd = shadow;
    if (shadow_we) begin
      shadow_upd[bus.pos[2:0]] = bus.data;
    end
  end

  // The display copy lands on the same edge that enters COMMIT, so the
  // buffer and frame_done change together right after the pos==7 sample.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      expected   <= 3'd0;
      shadow     <= '0;
      display    <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_next;
      expected   <= expected_next;
      shadow     <= shadow_upd;
      frame_done <= commit;
      frame_err  <= err_next;
      if (commit) begin
        display <= shadow_upd;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      err_cnt  <= '0;
      err_mode <= 1'b0;
    end else begin
      case (bus.status)
        2'b00: begin
          if (err_cnt != HOLD_MAX) begin
            err_cnt <= err_cnt + 1'b1;
          end
          if (err_cnt >= HOLD_LAST) begin
            err_mode <= 1'b1;
          end
        end
        2'b10: begin
          err_cnt  <= '0;
          err_mode <= 1'b0;
        end
        default: err_cnt <= '0;
      endcase
    end
  end

`ifdef CALC_DISP_LZB_EN
  logic [2:0] msd;
  always_comb begin
    msd = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (display[k] != 4'd0) begin
        msd = 3'(k);
      end
    end
  end
  assign blank = (idx > msd);
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    seg_next = SEG_BLANK;
    if (err_mode) begin
      case (idx)
        3'd3:       seg_next = SEG_E;
        3'd2, 3'd1: seg_next = SEG_R;
        3'd0:       seg_next = SEG_O;
        default:    seg_next = SEG_BLANK;
      endcase
    end else if (!blank) begin
      seg_next = encode(display[idx]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt <= '0;
      idx     <= 3'd0;
      an      <= 8'hFF;
      seg     <= SEG_BLANK;
    end else begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        idx     <= idx + 3'd1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      an  <= ~(8'h01 << idx);
      seg <= seg_next;
    end
  end

endmodule
`default_nettype wire
